pps_tod: RTL and testbench
==========================

PPS_TOD -- requirements
Module: pps_tod

Interface
REQ-001 SHALL have parameter CYC_PER_SEC, default 125_000_000; clk_125m cycles per nominal second.
REQ-002 SHALL have parameter NS_STEP, default 8; nanoseconds added per clk_125m cycle.
REQ-003 SHALL have parameter PERIOD_TOL, default 16; allowed deviation of a measured PPS period, in cycles.
REQ-004 SHALL have parameter LOCK_COUNT, default 3; consecutive good periods required to lock.
REQ-005 clk_125m  in  1  system clock; all logic in this single domain.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 pps_in  in  1  aligned PPS, already synchronous to clk_125m, 50% duty; only the rising edge is meaningful.
REQ-008 sec_load_valid  in  1  software seconds-load request.
REQ-009 sec_load_data  in  48  seconds value to apply at the next PPS edge.
REQ-010 sec_load_ready  out  1  load accepted when valid and ready are high in the same cycle.
REQ-011 tod_sec  out  48  time-of-day seconds.
REQ-012 tod_ns  out  30  time-of-day nanoseconds, always a multiple of NS_STEP.
REQ-013 tod_valid  out  1  high once a software seconds value has been applied.
REQ-014 pps_locked  out  1  high while the lock FSM is in LOCKED.
REQ-015 pps_missing  out  1  one-cycle pulse when the expected edge does not arrive.
REQ-016 period_err_cnt  out  16  count of out-of-tolerance periods; saturates at 0xFFFF.

Function
REQ-017 Rising edge SHALL be detected as pps_in=1 and previous-cycle pps_in=0 (one register), so edge_evt has 1 cycle latency.
REQ-018 tod_ns SHALL add NS_STEP every cycle; at NS_STEP*(CYC_PER_SEC-1) it SHALL wrap to 0 and tod_sec SHALL increment, wrapping modulo 2^48.
REQ-019 On edge_evt, tod_ns SHALL load 0 in the same cycle.
REQ-020 On edge_evt, tod_sec SHALL increment if tod_ns >= NS_STEP*CYC_PER_SEC/2 and otherwise hold, so a free-run wrap just before the edge is not double-counted.
REQ-021 A pending load on edge_evt SHALL set tod_sec to the loaded value (REQ-020 not applied), set tod_valid=1, and clear pending.
REQ-022 Handshake rules:
- sec_load_ready = not pending.
- Acceptance sets pending and captures the data.
- Acceptance coinciding with edge_evt applies at the following edge.
REQ-023 cyc_cnt (28 bits) SHALL reset to 0 on edge_evt, otherwise increment, saturating at all-ones.
REQ-024 A period is good when cyc_cnt+1 on edge_evt lies within CYC_PER_SEC ± PERIOD_TOL inclusive.
REQ-025 Timeout SHALL be cyc_cnt = CYC_PER_SEC+PERIOD_TOL with no edge_evt.
REQ-026 FSM states SHALL be UNLOCKED, ACQUIRE, LOCKED, HOLDOVER; good_cnt counts good periods.
REQ-027 UNLOCKED: any edge_evt -> ACQUIRE with good_cnt=0; no timeout checking.
REQ-028 ACQUIRE:
- good period -> good_cnt+1; reaching LOCK_COUNT -> LOCKED.
- bad period -> good_cnt=0, period_err_cnt+1, stay.
- timeout -> UNLOCKED with pps_missing pulse.
REQ-029 LOCKED:
- good period stays.
- bad period -> ACQUIRE, good_cnt=0, period_err_cnt+1.
- timeout -> HOLDOVER with pps_missing pulse.
REQ-030 HOLDOVER: tod free-runs per REQ-018; the next edge_evt -> ACQUIRE with good_cnt=0, and its period is not judged.
REQ-031 Edge and timeout SHALL never coincide; edge_evt takes priority.

Reset
REQ-032 While rst_n=0, all outputs and state SHALL be 0/idle:
- tod_sec=0, tod_ns=0, tod_valid=0, pps_locked=0, pps_missing=0, period_err_cnt=0.
- sec_load_ready=1, FSM=UNLOCKED, pending=0, cyc_cnt=0.
REQ-033 Reset mid-operation SHALL discard any pending load; tod_valid is not retained.

Structure
REQ-034 FSM state encoding and the 48/30/28-bit width constants SHALL live in the shared timing package.
REQ-035 The lock FSM with its period checker SHALL be one sub-module, pps_lock_fsm; counters and load logic stay in the top.

Verification (CYC_PER_SEC=1000, PERIOD_TOL=2, LOCK_COUNT=3, NS_STEP=8)
REQ-036 Edges every 1000 cycles -> pps_locked rises on the 4th edge; tod_ns=0 the cycle after each edge; period_err_cnt=0.
REQ-037 Load 0x12345 before an edge -> sec_load_ready low until that edge, then tod_sec=0x12345, tod_valid=1; next edge -> 0x12346.
REQ-038 While locked, one period of 1003 cycles -> period_err_cnt=1, pps_locked=0; locked again after 3 more good periods.
REQ-039 While locked, stop pps_in -> pps_missing pulse at cyc_cnt=1002; HOLDOVER; tod_sec keeps incrementing every 1000 cycles.
REQ-040 Load asserted in the edge_evt cycle -> tod_sec not loaded there; loaded at the following edge.
REQ-041 Assert rst_n low mid-LOCKED with a load pending -> all outputs zero, sec_load_ready=1; after release, tod_valid stays 0 until a new load is applied.

Source files
------------

// File: rtl/pps_tod_pkg.sv
// Shared timing definitions for the PPS time-of-day block: field widths,
// lock-FSM state encoding and a small saturating-increment helper.
package pps_tod_pkg;

    localparam int unsigned SEC_W = 48;
    localparam int unsigned NS_W  = 30;
    localparam int unsigned CYC_W = 28;
    localparam int unsigned ERR_W = 16;
    localparam int unsigned GOOD_W = 16;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2,
        ST_HOLDOVER = 2'd3
    } lock_state_e;

    function automatic logic [ERR_W-1:0] sat_inc_err(input logic [ERR_W-1:0] v);
        return (v == {ERR_W{1'b1}}) ? v : v + ERR_W'(1);
    endfunction

endpackage

// File: rtl/pps_tod_lock_fsm.sv
// PPS period checker and lock FSM: measures the cycle count between PPS edges,
// judges each period against the tolerance window and tracks lock state.
module pps_lock_fsm
    import pps_tod_pkg::*;
#(
    parameter int unsigned CYC_PER_SEC = 125_000_000,
    parameter int unsigned PERIOD_TOL  = 16,
    parameter int unsigned LOCK_COUNT  = 3
) (
    input  logic             clk_125m,
    input  logic             rst_n,
    input  logic             edge_evt_i,
    output logic             locked_o,
    output logic             missing_o,
    output logic [ERR_W-1:0] err_cnt_o
);

    localparam logic [CYC_W-1:0]  PER_MIN  = CYC_W'(CYC_PER_SEC - PERIOD_TOL);
    localparam logic [CYC_W-1:0]  PER_MAX  = CYC_W'(CYC_PER_SEC + PERIOD_TOL);
    localparam logic [GOOD_W-1:0] LOCK_TGT = GOOD_W'(LOCK_COUNT);

    lock_state_e       state_q;
    logic [CYC_W-1:0]  cyc_cnt_q;
    logic [GOOD_W-1:0] good_cnt_q;
    logic              locked_q;
    logic              missing_q;
    logic [ERR_W-1:0]  err_cnt_q;

    logic [CYC_W-1:0]  period_len;
    logic [GOOD_W-1:0] good_inc;
    logic              period_good;
    logic              timeout;

    // A saturated counter wraps to 0 here, which correctly lands outside the window.
    assign period_len  = cyc_cnt_q + CYC_W'(1);
    assign period_good = (period_len >= PER_MIN) && (period_len <= PER_MAX);
    assign timeout     = (cyc_cnt_q == PER_MAX);
    assign good_inc    = good_cnt_q + GOOD_W'(1);

    always_ff @(posedge clk_125m or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_UNLOCKED;
            cyc_cnt_q  <= '0;
            good_cnt_q <= '0;
            locked_q   <= 1'b0;
            missing_q  <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            missing_q <= 1'b0;

            if (edge_evt_i) begin
                cyc_cnt_q <= '0;
            end else if (cyc_cnt_q != {CYC_W{1'b1}}) begin
                cyc_cnt_q <= cyc_cnt_q + CYC_W'(1);
            end

            // Edge events always win over timeout in the same cycle.
            case (state_q)
                ST_UNLOCKED: begin
                    if (edge_evt_i) begin
                        state_q    <= ST_ACQUIRE;
                        good_cnt_q <= '0;
                    end
                end
                ST_ACQUIRE: begin
                    if (edge_evt_i) begin
                        if (period_good) begin
                            good_cnt_q <= good_inc;
                            if (good_inc >= LOCK_TGT) begin
                                state_q  <= ST_LOCKED;
                                locked_q <= 1'b1;
                            end
                        end else begin
                            good_cnt_q <= '0;
                            err_cnt_q  <= sat_inc_err(err_cnt_q);
                        end
                    end else if (timeout) begin
                        state_q   <= ST_UNLOCKED;
                        missing_q <= 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (edge_evt_i) begin
                        if (!period_good) begin
                            state_q    <= ST_ACQUIRE;
                            locked_q   <= 1'b0;
                            good_cnt_q <= '0;
                            err_cnt_q  <= sat_inc_err(err_cnt_q);
                        end
                    end else if (timeout) begin
                        state_q   <= ST_HOLDOVER;
                        locked_q  <= 1'b0;
                        missing_q <= 1'b1;
                    end
                end
                ST_HOLDOVER: begin
                    // The gap leading into this edge is meaningless, so it is not judged.
                    if (edge_evt_i) begin
                        state_q    <= ST_ACQUIRE;
                        good_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q <= ST_UNLOCKED;
                end
            endcase
        end
    end

    assign locked_o  = locked_q;
    assign missing_o = missing_q;
    assign err_cnt_o = err_cnt_q;

endmodule

// File: rtl/pps_tod.sv
// PPS-disciplined time-of-day counter: free-running seconds/nanoseconds,
// realigned on each PPS edge, with a software seconds-load handshake.
module pps_tod
    import pps_tod_pkg::*;
#(
    parameter int unsigned CYC_PER_SEC = 125_000_000,
    parameter int unsigned NS_STEP     = 8,
    parameter int unsigned PERIOD_TOL  = 16,
    parameter int unsigned LOCK_COUNT  = 3
) (
    input  logic             clk_125m,
    input  logic             rst_n,
    input  logic             pps_in,
    input  logic             sec_load_valid,
    input  logic [SEC_W-1:0] sec_load_data,
    output logic             sec_load_ready,
    output logic [SEC_W-1:0] tod_sec,
    output logic [NS_W-1:0]  tod_ns,
    output logic             tod_valid,
    output logic             pps_locked,
    output logic             pps_missing,
    output logic [ERR_W-1:0] period_err_cnt
);

    localparam logic [NS_W-1:0] NS_INC  = NS_W'(NS_STEP);
    localparam logic [NS_W-1:0] NS_LAST = NS_W'(NS_STEP * (CYC_PER_SEC - 1));
    localparam logic [NS_W-1:0] NS_HALF = NS_W'((NS_STEP * CYC_PER_SEC) / 2);

    logic             pps_prev_q;
    logic [SEC_W-1:0] tod_sec_q,   tod_sec_d;
    logic [NS_W-1:0]  tod_ns_q,    tod_ns_d;
    logic             tod_valid_q, tod_valid_d;
    logic             pending_q,   pending_d;
    logic [SEC_W-1:0] load_data_q, load_data_d;

    logic edge_evt;
    logic load_accept;

    assign edge_evt    = pps_in & ~pps_prev_q;
    assign load_accept = sec_load_valid & ~pending_q;

    always_comb begin
        tod_sec_d   = tod_sec_q;
        tod_ns_d    = tod_ns_q;
        tod_valid_d = tod_valid_q;
        pending_d   = pending_q;
        load_data_d = load_data_q;

        if (edge_evt) begin
            tod_ns_d = '0;
            if (pending_q) begin
                tod_sec_d   = load_data_q;
                tod_valid_d = 1'b1;
                pending_d   = 1'b0;
            end else if (tod_ns_q >= NS_HALF) begin
                // Late in the second: the edge marks a new second. Early: the
                // free-run wrap already counted it.
                tod_sec_d = tod_sec_q + SEC_W'(1);
            end
        end else if (tod_ns_q >= NS_LAST) begin
            tod_ns_d  = '0;
            tod_sec_d = tod_sec_q + SEC_W'(1);
        end else begin
            tod_ns_d = tod_ns_q + NS_INC;
        end

        // Ready is low whenever pending is set, so this never collides with the apply above.
        if (load_accept) begin
            pending_d   = 1'b1;
            load_data_d = sec_load_data;
        end
    end

    always_ff @(posedge clk_125m or negedge rst_n) begin
        if (!rst_n) begin
            pps_prev_q  <= 1'b0;
            tod_sec_q   <= '0;
            tod_ns_q    <= '0;
            tod_valid_q <= 1'b0;
            pending_q   <= 1'b0;
            load_data_q <= '0;
        end else begin
            pps_prev_q  <= pps_in;
            tod_sec_q   <= tod_sec_d;
            tod_ns_q    <= tod_ns_d;
            tod_valid_q <= tod_valid_d;
            pending_q   <= pending_d;
            load_data_q <= load_data_d;
        end
    end

    pps_lock_fsm #(
        .CYC_PER_SEC (CYC_PER_SEC),
        .PERIOD_TOL  (PERIOD_TOL),
        .LOCK_COUNT  (LOCK_COUNT)
    ) u_lock_fsm (
        .clk_125m   (clk_125m),
        .rst_n      (rst_n),
        .edge_evt_i (edge_evt),
        .locked_o   (pps_locked),
        .missing_o  (pps_missing),
        .err_cnt_o  (period_err_cnt)
    );

    assign sec_load_ready = ~pending_q;
    assign tod_sec        = tod_sec_q;
    assign tod_ns         = tod_ns_q;
    assign tod_valid      = tod_valid_q;

endmodule

// File: tb/tb_pps_tod.sv
// Directed bench for pps_tod with a 1000-cycle nominal second: lock-up,
// seconds load, bad period, PPS loss/holdover and mid-operation reset.
module tb_pps_tod;

    localparam int unsigned CYC = 1000;
    localparam int unsigned TOL = 2;
    localparam int unsigned LCK = 3;
    localparam int unsigned NSS = 8;

    logic        clk_125m = 1'b0;
    logic        rst_n = 1'b0;
    logic        pps_in = 1'b0;
    logic        sec_load_valid = 1'b0;
    logic [47:0] sec_load_data = '0;
    logic        sec_load_ready;
    logic [47:0] tod_sec;
    logic [29:0] tod_ns;
    logic        tod_valid;
    logic        pps_locked;
    logic        pps_missing;
    logic [15:0] period_err_cnt;

    int n_vec = 0;
    int n_bad = 0;

    always #4 clk_125m = ~clk_125m;

    pps_tod #(
        .CYC_PER_SEC (CYC),
        .NS_STEP     (NSS),
        .PERIOD_TOL  (TOL),
        .LOCK_COUNT  (LCK)
    ) dut (
        .clk_125m       (clk_125m),
        .rst_n          (rst_n),
        .pps_in         (pps_in),
        .sec_load_valid (sec_load_valid),
        .sec_load_data  (sec_load_data),
        .sec_load_ready (sec_load_ready),
        .tod_sec        (tod_sec),
        .tod_ns         (tod_ns),
        .tod_valid      (tod_valid),
        .pps_locked     (pps_locked),
        .pps_missing    (pps_missing),
        .period_err_cnt (period_err_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clk_125m);
            #1;
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".sec"},    64'(tod_sec), 64'd0);
        check({tag, ".ns"},     64'(tod_ns), 64'd0);
        check({tag, ".valid"},  64'(tod_valid), 64'd0);
        check({tag, ".locked"}, 64'(pps_locked), 64'd0);
        check({tag, ".miss"},   64'(pps_missing), 64'd0);
        check({tag, ".err"},    64'(period_err_cnt), 64'd0);
        check({tag, ".ready"},  64'(sec_load_ready), 64'd1);
    endtask

    // One PPS period of n cycles starting with a rising edge; optional load
    // request in cycle load_at; checks state right after the edge is taken.
    task automatic run_period(input string name, input int n, input int load_at,
                              input logic [47:0] ld, input logic exp_lock,
                              input logic [15:0] exp_err);
        sec_load_data = ld;
        for (int i = 0; i < n; i++) begin
            pps_in         = (i < n / 2) ? 1'b1 : 1'b0;
            sec_load_valid = (i == load_at) ? 1'b1 : 1'b0;
            tick(1);
            if (i == 0) begin
                check({name, ".ns0"},    64'(tod_ns), 64'd0);
                check({name, ".locked"}, 64'(pps_locked), 64'(exp_lock));
                check({name, ".err"},    64'(period_err_cnt), 64'(exp_err));
            end
        end
        sec_load_valid = 1'b0;
    endtask

    initial begin
        int first_j;
        int pulses;

        tick(3);
        check_idle("reset");
        rst_n = 1'b1;
        tick(10);

        // Lock-up: locked appears on the 4th edge; seconds advance from edge 2 on
        run_period("E1", 1000, -1, 48'd0, 1'b0, 16'd0);
        run_period("E2", 1000, -1, 48'd0, 1'b0, 16'd0);
        run_period("E3", 1000, -1, 48'd0, 1'b0, 16'd0);
        run_period("E4", 1000, 1, 48'h12345, 1'b1, 16'd0);
        check("E4.sec_free",  64'(tod_sec), 64'd3);
        check("E4.ready_lo",  64'(sec_load_ready), 64'd0);
        check("E4.valid_lo",  64'(tod_valid), 64'd0);

        run_period("E5", 1000, -1, 48'd0, 1'b1, 16'd0);
        check("E5.sec_load",  64'(tod_sec), 64'h12345);
        check("E5.valid",     64'(tod_valid), 64'd1);
        check("E5.ready",     64'(sec_load_ready), 64'd1);
        run_period("E6", 1000, -1, 48'd0, 1'b1, 16'd0);
        check("E6.sec_inc",   64'(tod_sec), 64'h12346);

        // One long period drops lock; three good periods regain it
        run_period("E7",  1003, -1, 48'd0, 1'b1, 16'd0);
        run_period("E8",  1000, -1, 48'd0, 1'b0, 16'd1);
        run_period("E9",  1000, -1, 48'd0, 1'b0, 16'd1);
        run_period("E10", 1000, -1, 48'd0, 1'b0, 16'd1);
        run_period("E11", 1000, -1, 48'd0, 1'b1, 16'd1);
        check("E11.sec_nodbl", 64'(tod_sec), 64'h1234B);

        // Load raised in the same cycle as the edge applies one edge later
        run_period("E12", 1000, 0, 48'h777, 1'b1, 16'd1);
        check("E12.sec_noload", 64'(tod_sec), 64'h1234C);
        check("E12.ready_lo",   64'(sec_load_ready), 64'd0);
        run_period("E13", 1000, -1, 48'd0, 1'b1, 16'd1);
        check("E13.sec_load",   64'(tod_sec), 64'h777);
        check("E13.ready",      64'(sec_load_ready), 64'd1);

        // PPS stops: missing pulse at cyc_cnt=1002 (visible 4 ticks later here)
        first_j = -1;
        pulses  = 0;
        for (int j = 1; j <= 20; j++) begin
            tick(1);
            if (pps_missing) begin
                pulses++;
                if (first_j < 0) first_j = j;
            end
        end
        check("loss.miss_at",    64'(first_j), 64'd4);
        check("loss.miss_width", 64'(pulses), 64'd1);
        check("loss.locked",     64'(pps_locked), 64'd0);
        check("loss.sec1",       64'(tod_sec), 64'h778);
        tick(1000);
        check("loss.sec2",       64'(tod_sec), 64'h779);
        check("loss.err",        64'(period_err_cnt), 64'd1);

        // Recovery from holdover; the gap period is not counted as an error
        run_period("E14", 1000, -1, 48'd0, 1'b0, 16'd1);
        run_period("E15", 1000, -1, 48'd0, 1'b0, 16'd1);
        run_period("E16", 1000, -1, 48'd0, 1'b0, 16'd1);
        run_period("E17", 1000, 5, 48'hABC, 1'b1, 16'd1);
        check("E17.ready_lo", 64'(sec_load_ready), 64'd0);

        // Asynchronous reset while locked with a load pending
        rst_n = 1'b0;
        #1;
        check_idle("rst_mid");
        tick(3);
        rst_n = 1'b1;
        tick(5);
        run_period("P1", 1000, -1, 48'd0, 1'b0, 16'd0);
        check("P1.valid", 64'(tod_valid), 64'd0);
        check("P1.sec",   64'(tod_sec), 64'd0);
        run_period("P2", 1000, -1, 48'd0, 1'b0, 16'd0);
        check("P2.valid", 64'(tod_valid), 64'd0);
        check("P2.sec",   64'(tod_sec), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
